// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and register-file state encoding.
package mips_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_ZERO  = 0;

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: address decode, zero-register masking and
// same-cycle write forwarding.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned NUM_WR   = 1,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     active,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [DEPTH*DATA_W-1:0]  regs,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]        rdata
);

    always_comb begin
        rdata = regs[int'(raddr)*DATA_W +: DATA_W];
        // Ascending scan so the highest-numbered matching write port wins.
        if (BYPASS) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (we[j] && waddr[j*ADDR_W +: ADDR_W] == raddr)
                    rdata = wdata[j*DATA_W +: DATA_W];
            end
        end
        if (!active || (ZERO_REG && raddr == ADDR_W'(REG_ZERO)))
            rdata = '0;
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file with post-reset clear sweep, optional
// hardwired-zero R0 and optional write-to-read bypass.
module mips_regfile_mp
    import mips_pkg::*;
#(
    parameter int unsigned       DATA_W   = mips_pkg::DATA_W,
    parameter int unsigned       DEPTH    = REG_COUNT,
    parameter int unsigned       ADDR_W   = $clog2(DEPTH),
    parameter int unsigned       NUM_RD   = 2,
    parameter int unsigned       NUM_WR   = 1,
    parameter bit                ZERO_REG = 1'b1,
    parameter bit                BYPASS   = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    output logic                     ready
);

    rf_state_e                state;
    logic [ADDR_W-1:0]        idx;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DEPTH*DATA_W-1:0]  regs_flat;
    logic                     rd_active;

    // Storage is deliberately untouched by reset; the sweep clears it afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RF_CLEAR;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    mem[idx] <= CLR_VAL;
                    if (idx == ADDR_W'(DEPTH - 1)) begin
                        state <= RF_READY;
                        ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RF_READY: begin
                    for (int unsigned j = 0; j < NUM_WR; j++) begin
                        if (we[j] && !(ZERO_REG && waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)))
                            mem[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
                    end
                end
                default: state <= RF_CLEAR;
            endcase
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            regs_flat[i*DATA_W +: DATA_W] = mem[i];
    end

    // Reset is folded in combinationally so rdata reads 0 as soon as reset drops.
    assign rd_active = reset && (state == RF_READY);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .active (rd_active),
            .raddr  (raddr[i*ADDR_W +: ADDR_W]),
            .regs   (regs_flat),
            .we     (we),
            .waddr  (waddr),
            .wdata  (wdata),
            .rdata  (rdata[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed bench: a 2-write bypassing file and a 1-write non-bypassing file
// sharing clock and reset.
module tb_mips_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        ready;

    logic [4:0]  raddr_nb;
    logic [31:0] rdata_nb;
    logic [0:0]  we_nb;
    logic [4:0]  waddr_nb;
    logic [31:0] wdata_nb;
    logic        ready_nb;

    int errors = 0;
    int checks = 0;
    int cnt;

    always #5 clk = ~clk;

    mips_regfile_mp #(
        .DATA_W (32), .DEPTH (32), .NUM_RD (2), .NUM_WR (2),
        .ZERO_REG (1'b1), .BYPASS (1'b1), .CLR_VAL (32'h0)
    ) u_dut (
        .clk (clk), .reset (reset), .raddr (raddr), .rdata (rdata),
        .we (we), .waddr (waddr), .wdata (wdata), .ready (ready)
    );

    mips_regfile_mp #(
        .DATA_W (32), .DEPTH (32), .NUM_RD (1), .NUM_WR (1),
        .ZERO_REG (1'b1), .BYPASS (1'b0), .CLR_VAL (32'h0)
    ) u_nb (
        .clk (clk), .reset (reset), .raddr (raddr_nb), .rdata (rdata_nb),
        .we (we_nb), .waddr (waddr_nb), .wdata (wdata_nb), .ready (ready_nb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        cnt = 0;
        while (!ready && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 20) begin
                chk({tag, "_clear_rdata0"}, rdata[31:0], 32'h0);
                chk({tag, "_clear_ready"}, {31'b0, ready}, 32'h0);
            end
        end
        chk({tag, "_cycles"}, cnt, 32'd32);
        chk({tag, "_ready_nb"}, {31'b0, ready_nb}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; raddr = '0; we = '0; waddr = '0; wdata = '0;
        raddr_nb = '0; we_nb = '0; waddr_nb = '0; wdata_nb = '0;
        repeat (3) tick();
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_ready_nb", {31'b0, ready_nb}, 32'h0);
        chk("rst_rdata", rdata[31:0], 32'h0);

        // Writes during the whole sweep must be ignored.
        reset = 1'b1;
        we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'hAA}; raddr = {5'd0, 5'd9};
        wait_ready("sweep1");
        we = '0;
        #1;
        chk("clear_write_ignored", rdata[31:0], 32'h0);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'd0, 5'(a)};
            #1;
            chk($sformatf("clr_read_%0d", a), rdata[31:0], 32'h0);
        end

        // Bypass vs no bypass.
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF}; raddr = {5'd0, 5'd5};
        we_nb = 1'b1; waddr_nb = 5'd5; wdata_nb = 32'hDEADBEEF; raddr_nb = 5'd5;
        #1;
        chk("bypass_same", rdata[31:0], 32'hDEADBEEF);
        chk("nobypass_same", rdata_nb, 32'h0);
        tick();
        we = '0; we_nb = '0;
        #1;
        chk("bypass_next", rdata[31:0], 32'hDEADBEEF);
        chk("nobypass_next", rdata_nb, 32'hDEADBEEF);

        // Register 0 stays zero.
        we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF}; raddr = {5'd0, 5'd0};
        we_nb = 1'b1; waddr_nb = 5'd0; wdata_nb = 32'hFFFFFFFF; raddr_nb = 5'd0;
        #1;
        chk("zero_same", rdata[31:0], 32'h0);
        chk("zero_same_port1", rdata[63:32], 32'h0);
        tick();
        we = '0; we_nb = '0;
        #1;
        chk("zero_next", rdata[31:0], 32'h0);
        chk("zero_next_nb", rdata_nb, 32'h0);

        // Both ports to reg 7: port 1 wins, also on the bypass path.
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'd22, 32'd11}; raddr = {5'd7, 5'd5};
        #1;
        chk("dual_bypass_p1", rdata[63:32], 32'd22);
        chk("other_port_p0", rdata[31:0], 32'hDEADBEEF);
        tick();
        we = '0;
        #1;
        chk("dual_same_addr", rdata[63:32], 32'd22);

        // Both ports to distinct registers.
        we = 2'b11; waddr = {5'd9, 5'd8}; wdata = {32'h99, 32'h88};
        tick();
        we = '0; raddr = {5'd9, 5'd8};
        #1;
        chk("dual_distinct_p0", rdata[31:0], 32'h88);
        chk("dual_distinct_p1", rdata[63:32], 32'h99);

        // Reset mid-sweep restarts it.
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h1234};
        tick();
        we = '0; raddr = {5'd5, 5'd3};
        #1;
        chk("reg3_written", rdata[31:0], 32'h1234);
        reset = 1'b0;
        #1;
        chk("rdata_reset_low", rdata[31:0], 32'h0);
        tick();
        reset = 1'b1;
        repeat (10) tick();
        chk("midsweep_ready", {31'b0, ready}, 32'h0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wait_ready("sweep2");
        #1;
        chk("reg3_cleared", rdata[31:0], 32'h0);
        chk("reg5_cleared", rdata[63:32], 32'h0);
        raddr_nb = 5'd5;
        #1;
        chk("reg5_cleared_nb", rdata_nb, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
